// File: rtl/lcd_bus_arbiter_pkg.sv
// Shared LCD definitions: word layout, arbiter state encoding and round-robin pointer helper.
package lcd_pkg;

    localparam int unsigned LCD_DC_BIT      = 8;
    localparam int unsigned LCD_DW          = LCD_DC_BIT + 1;
    localparam int unsigned LCD_TIMEOUT_DEF = 4096;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OWN,
        ARB_FLIGHT
    } arb_state_t;

    typedef logic [2:0] port_idx_t;

    // Port 0 never advances the pointer; the last port wraps back to 1.
    function automatic port_idx_t rr_next(input port_idx_t cur, input port_idx_t owner,
                                          input int unsigned num_req);
        if (owner == '0) begin
            return cur;
        end else if (owner == port_idx_t'(num_req - 1)) begin
            return port_idx_t'(1);
        end else begin
            return owner + port_idx_t'(1);
        end
    endfunction

endpackage

// File: rtl/lcd_bus_arbiter_if.sv
// Producer-side and lcd_write-side handshake bundle of the LCD bus arbiter.
interface lcd_bus_arbiter_if #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned DW      = lcd_pkg::LCD_DW
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    wr_en;
    logic [NUM_REQ*DW-1:0] wr_data;
    logic [NUM_REQ-1:0]    gnt;
    logic                  busy;
    logic [NUM_REQ-1:0]    wr_done_o;
    logic [DW-1:0]         data;
    logic                  en_write;
    logic                  wr_done;

    modport slave (
        input  req, wr_en, wr_data, wr_done,
        output gnt, busy, wr_done_o, data, en_write
    );

    modport master (
        output req, wr_en, wr_data, wr_done,
        input  gnt, busy, wr_done_o, data, en_write
    );
endinterface

// File: rtl/lcd_rr_pick.sv
// Rotate-priority encoder: port 0 strict priority, ports >= 1 round-robin from rr_ptr once init is done.
module lcd_rr_pick
    import lcd_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  port_idx_t          rr_ptr,
    input  logic               init_done,
    output logic [NUM_REQ-1:0] winner
);

    always_comb begin
        int unsigned p;
        logic        found;
        winner = '0;
        found  = 1'b0;
        p      = 0;
        if (req[0]) begin
            winner[0] = 1'b1;
        end else if (init_done) begin
            // Candidate sequence rr_ptr, rr_ptr+1, ... within ports 1..NUM_REQ-1.
            for (int unsigned i = 0; i < NUM_REQ - 1; i++) begin
                p = ((32'(rr_ptr) - 1 + i) % (NUM_REQ - 1)) + 1;
                if (!found && req[p]) begin
                    winner[p] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Shares one lcd_write engine among NUM_REQ word producers: whole-burst grants,
// one word in flight at a time, owner-only completion routing and per-word timeout.
module lcd_bus_arbiter
    import lcd_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned DW      = LCD_DW,
    parameter int unsigned TIMEOUT = LCD_TIMEOUT_DEF
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               init_done,
    lcd_bus_arbiter_if.slave   bus,
    output logic               drop_err,
    output logic               tmo_err
);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    port_idx_t          owner_q, owner_d;
    port_idx_t          rr_ptr_q, rr_ptr_d;
    logic [DW-1:0]      data_q, data_d;
    logic               en_write_q, en_write_d;
    logic               busy_q, busy_d;
    logic               drop_err_q, drop_err_d;
    logic               tmo_err_q, tmo_err_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               init_seen_q, init_seen_d;
    logic [NUM_REQ-1:0] winner;
    port_idx_t          winner_idx;

    lcd_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req       (bus.req),
        .rr_ptr    (rr_ptr_q),
        .init_done (init_done | init_seen_q),
        .winner    (winner)
    );

    always_comb begin
        winner_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) winner_idx = port_idx_t'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        data_d      = data_q;
        en_write_d  = 1'b0;
        busy_d      = busy_q;
        tmo_err_d   = 1'b0;
        cnt_d       = cnt_q;
        init_seen_d = init_seen_q | init_done;
        drop_err_d  = (|(bus.wr_en & ~gnt_q)) |
                      ((state_q == ARB_FLIGHT) && (|(bus.wr_en & gnt_q)));
        unique case (state_q)
            ARB_IDLE: begin
                if (|winner) begin
                    gnt_d   = winner;
                    owner_d = winner_idx;
                    state_d = ARB_OWN;
                end
            end
            ARB_OWN: begin
                // A word strobed together with req falling is sent first; release follows it.
                if (bus.wr_en[owner_q]) begin
                    data_d     = bus.wr_data[owner_q*DW +: DW];
                    en_write_d = 1'b1;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    state_d    = ARB_FLIGHT;
                end else if (!bus.req[owner_q]) begin
                    gnt_d    = '0;
                    rr_ptr_d = rr_next(rr_ptr_q, owner_q, NUM_REQ);
                    state_d  = ARB_IDLE;
                end
            end
            ARB_FLIGHT: begin
                cnt_d = cnt_q + 16'd1;
                if (bus.wr_done) begin
                    busy_d  = 1'b0;
                    state_d = ARB_OWN;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    tmo_err_d = 1'b1;
                    busy_d    = 1'b0;
                    gnt_d     = '0;
                    state_d   = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= port_idx_t'(1);
            data_q      <= '0;
            en_write_q  <= 1'b0;
            busy_q      <= 1'b0;
            drop_err_q  <= 1'b0;
            tmo_err_q   <= 1'b0;
            cnt_q       <= '0;
            init_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            data_q      <= data_d;
            en_write_q  <= en_write_d;
            busy_q      <= busy_d;
            drop_err_q  <= drop_err_d;
            tmo_err_q   <= tmo_err_d;
            cnt_q       <= cnt_d;
            init_seen_q <= init_seen_d;
        end
    end

    // Completion is routed only while a word is actually in flight, so a late pulse is ignored.
    assign bus.wr_done_o = (state_q == ARB_FLIGHT && bus.wr_done) ? gnt_q : '0;
    assign bus.gnt       = gnt_q;
    assign bus.busy      = busy_q;
    assign bus.data      = data_q;
    assign bus.en_write  = en_write_q;
    assign drop_err      = drop_err_q;
    assign tmo_err       = tmo_err_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Self-checking bench for lcd_bus_arbiter: producer tasks, an lcd_write model and a word scoreboard.
module tb_lcd_bus_arbiter;
    import lcd_pkg::*;

    localparam int unsigned N = 3;

    typedef struct packed {
        logic [N-1:0]  gnt;
        logic [8:0]    data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic init_done;
    logic init_t;
    logic drop_err, tmo_err, drop_t, tmo_t;

    lcd_bus_arbiter_if #(.NUM_REQ(N), .DW(LCD_DW)) bus ();
    lcd_bus_arbiter_if #(.NUM_REQ(N), .DW(LCD_DW)) bus_t ();

    lcd_bus_arbiter #(.NUM_REQ(N), .DW(LCD_DW), .TIMEOUT(256)) u_dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .init_done(init_done),
        .bus(bus), .drop_err(drop_err), .tmo_err(tmo_err)
    );

    lcd_bus_arbiter #(.NUM_REQ(N), .DW(LCD_DW), .TIMEOUT(16)) u_dut_t (
        .sys_clk(clk), .sys_rst_n(rst_n), .init_done(init_t),
        .bus(bus_t), .drop_err(drop_t), .tmo_err(tmo_t)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];
    int   done_delay = 3;
    int   en_cnt = 0;
    int   done_cnt [N];
    int   rst_gen = 0;
    int   glog[$];
    int   gap[$];
    int   zero_run = 0;
    logic [N-1:0] prev_gnt = '0;

    function automatic int oh_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    always @(negedge rst_n) rst_gen++;

    // Grant-order monitor.
    initial forever begin
        @(negedge clk);
        if (bus.gnt == '0) begin
            zero_run++;
        end else if (bus.gnt != prev_gnt) begin
            glog.push_back(oh_idx(bus.gnt));
            gap.push_back(zero_run);
            zero_run = 0;
        end
        prev_gnt = bus.gnt;
    end

    // lcd_write model: checks each strobed word against the scoreboard, answers after done_delay.
    initial begin
        exp_t e;
        int   gen;
        bus.wr_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.en_write === 1'b1) begin
                en_cnt++;
                gen = rst_gen;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_word: en_write with gnt=%b data=%h, required no strobe", bus.gnt, bus.data);
                end else begin
                    e = sb_q.pop_front();
                    if ({bus.gnt, bus.data} !== {e.gnt, e.data}) begin
                        errors++;
                        $display("FAIL sb_word: gnt=%b data=%h, required gnt=%b data=%h", bus.gnt, bus.data, e.gnt, e.data);
                    end
                end
                for (int d = 0; d < done_delay; d++) @(negedge clk);
                if (gen == rst_gen) begin
                    bus.wr_done = 1'b1;
                    #1;
                    checks++;
                    if (bus.wr_done_o !== bus.gnt) begin
                        errors++;
                        $display("FAIL done_route: wr_done_o=%b, required %b", bus.wr_done_o, bus.gnt);
                    end
                    for (int i = 0; i < N; i++) done_cnt[i] += int'(bus.wr_done_o[i]);
                    @(negedge clk);
                    bus.wr_done = 1'b0;
                end
            end
        end
    end

    task automatic burst(input int p, input int n, input logic [8:0] w0, input logic [8:0] w1);
        int   t;
        exp_t e;
        bus.req[p] = 1'b1;
        for (int k = 0; k < n; k++) begin
            t = 0;
            while (!(bus.gnt[p] === 1'b1 && bus.busy === 1'b0) && t < 400) begin
                @(negedge clk);
                t++;
            end
            checks++;
            if (t >= 400) begin
                errors++;
                $display("FAIL burst_gnt: port %0d gnt=%b busy=%b, required grant within 400 cycles", p, bus.gnt, bus.busy);
                break;
            end
            e.gnt    = '0;
            e.gnt[p] = 1'b1;
            e.data   = (k == 0) ? w0 : w1;
            sb_q.push_back(e);
            bus.wr_data[p*LCD_DW +: LCD_DW] = e.data;
            bus.wr_en[p] = 1'b1;
            @(negedge clk);
            bus.wr_en[p] = 1'b0;
        end
        t = 0;
        while (bus.busy !== 1'b0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        bus.req[p] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (bus.gnt !== '0 || bus.busy !== 1'b0 || bus.en_write !== 1'b0 || bus.data !== '0 ||
            bus.wr_done_o !== '0 || drop_err !== 1'b0 || tmo_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: gnt=%b busy=%b en=%b data=%h done_o=%b drop=%b tmo=%b, required all 0",
                     bus.gnt, bus.busy, bus.en_write, bus.data, bus.wr_done_o, drop_err, tmo_err);
        end
        bus.req = 3'b110;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (bus.gnt !== 3'b000) begin
                errors++;
                $display("FAIL init_gate: gnt=%b, required 000", bus.gnt);
            end
        end
        bus.req[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 3'b001) begin
            errors++;
            $display("FAIL port0_gnt: gnt=%b, required 001", bus.gnt);
        end
        bus.req = '0;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 3'b000) begin
            errors++;
            $display("FAIL port0_release: gnt=%b, required 000", bus.gnt);
        end
    endtask

    task automatic test_port0_burst;
        int e0, d0, d1;
        done_delay = 20;
        e0 = en_cnt;
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        burst(0, 2, 9'h011, 9'h136);
        checks++;
        if (en_cnt - e0 != 2) begin
            errors++;
            $display("FAIL p0_en_count: %0d strobes, required 2", en_cnt - e0);
        end
        checks++;
        if (done_cnt[0] - d0 != 2) begin
            errors++;
            $display("FAIL p0_done0: %0d pulses, required 2", done_cnt[0] - d0);
        end
        checks++;
        if (done_cnt[1] - d1 != 0) begin
            errors++;
            $display("FAIL p0_done1: %0d pulses, required 0", done_cnt[1] - d1);
        end
    endtask

    task automatic test_round_robin;
        int exp_order [4] = '{1, 2, 1, 2};
        int e0;
        done_delay = 3;
        init_done  = 1'b1;
        e0 = en_cnt;
        glog.delete();
        gap.delete();
        zero_run = 0;
        fork
            begin
                burst(1, 2, 9'h110, 9'h111);
                burst(1, 2, 9'h112, 9'h113);
            end
            begin
                burst(2, 2, 9'h120, 9'h121);
                burst(2, 2, 9'h122, 9'h123);
            end
        join
        checks++;
        if (glog.size() != 4) begin
            errors++;
            $display("FAIL rr_count: %0d grants, required 4", glog.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (glog[i] != exp_order[i]) begin
                    errors++;
                    $display("FAIL rr_order[%0d]: port %0d, required %0d", i, glog[i], exp_order[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (gap[i] != 1) begin
                        errors++;
                        $display("FAIL rr_gap[%0d]: %0d idle cycles, required 1", i, gap[i]);
                    end
                end
            end
        end
        checks++;
        if (en_cnt - e0 != 8) begin
            errors++;
            $display("FAIL rr_en_count: %0d strobes, required 8", en_cnt - e0);
        end
    endtask

    task automatic test_drop;
        int e0;
        int t;
        e0 = en_cnt;
        fork
            burst(1, 2, 9'h1A0, 9'h1A1);
            begin
                t = 0;
                while (bus.gnt[1] !== 1'b1 && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                checks++;
                if (t >= 100) begin
                    errors++;
                    $display("FAIL drop_gnt: gnt=%b, required port 1 grant within 100 cycles", bus.gnt);
                end
                bus.wr_data[2*LCD_DW +: LCD_DW] = 9'h1FF;
                bus.wr_en[2] = 1'b1;
                @(negedge clk);
                bus.wr_en[2] = 1'b0;
                checks++;
                if (drop_err !== 1'b1) begin
                    errors++;
                    $display("FAIL drop_pulse: drop_err=%b, required 1", drop_err);
                end
                @(negedge clk);
                checks++;
                if (drop_err !== 1'b0) begin
                    errors++;
                    $display("FAIL drop_clear: drop_err=%b, required 0", drop_err);
                end
            end
        join
        checks++;
        if (en_cnt - e0 != 2) begin
            errors++;
            $display("FAIL drop_en_count: %0d strobes, required 2", en_cnt - e0);
        end
    endtask

    task automatic test_timeout;
        int t;
        int k;
        bus_t.req[1] = 1'b1;
        t = 0;
        while (bus_t.gnt[1] !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 50) begin
            errors++;
            $display("FAIL tmo_gnt: gnt=%b, required port 1 grant within 50 cycles", bus_t.gnt);
        end
        bus_t.wr_data[LCD_DW +: LCD_DW] = 9'h055;
        bus_t.wr_en[1] = 1'b1;
        @(negedge clk);
        bus_t.wr_en[1] = 1'b0;
        checks++;
        if (bus_t.en_write !== 1'b1 || bus_t.data !== 9'h055) begin
            errors++;
            $display("FAIL tmo_strobe: en_write=%b data=%h, required 1 and 055", bus_t.en_write, bus_t.data);
        end
        k = 0;
        while (tmo_t !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != 16) begin
            errors++;
            $display("FAIL tmo_latency: tmo_err after %0d cycles, required 16", k);
        end
        checks++;
        if (bus_t.gnt !== 3'b000 || bus_t.busy !== 1'b0 || drop_t !== 1'b0) begin
            errors++;
            $display("FAIL tmo_release: gnt=%b busy=%b drop=%b, required 000 0 0", bus_t.gnt, bus_t.busy, drop_t);
        end
        bus_t.wr_done = 1'b1;
        #1;
        checks++;
        if (bus_t.wr_done_o !== 3'b000) begin
            errors++;
            $display("FAIL tmo_late_done: wr_done_o=%b, required 000", bus_t.wr_done_o);
        end
        bus_t.req = 3'b100;
        @(negedge clk);
        bus_t.wr_done = 1'b0;
        checks++;
        if (tmo_t !== 1'b0 || bus_t.gnt !== 3'b100) begin
            errors++;
            $display("FAIL tmo_regrant: tmo_err=%b gnt=%b, required 0 and 100", tmo_t, bus_t.gnt);
        end
        bus_t.req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_async_reset;
        int   t;
        exp_t e;
        done_delay = 100;
        bus.req[2] = 1'b1;
        t = 0;
        while (bus.gnt[2] !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 50) begin
            errors++;
            $display("FAIL ar_gnt: gnt=%b, required port 2 grant within 50 cycles", bus.gnt);
        end
        e.gnt  = 3'b100;
        e.data = 9'h0A5;
        sb_q.push_back(e);
        bus.wr_data[2*LCD_DW +: LCD_DW] = 9'h0A5;
        bus.wr_en[2] = 1'b1;
        @(negedge clk);
        bus.wr_en[2] = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL ar_flight: busy=%b, required 1", bus.busy);
        end
        #2;
        rst_n   = 1'b0;
        bus.req = '0;
        #1;
        checks++;
        if (bus.gnt !== '0 || bus.busy !== 1'b0 || bus.en_write !== 1'b0 || bus.data !== '0 ||
            bus.wr_done_o !== '0 || drop_err !== 1'b0 || tmo_err !== 1'b0) begin
            errors++;
            $display("FAIL ar_outputs: gnt=%b busy=%b en=%b data=%h done_o=%b drop=%b tmo=%b, required all 0",
                     bus.gnt, bus.busy, bus.en_write, bus.data, bus.wr_done_o, drop_err, tmo_err);
        end
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        bus.req = 3'b110;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 3'b010) begin
            errors++;
            $display("FAIL ar_rr_ptr: gnt=%b, required 010", bus.gnt);
        end
        bus.req = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d words never strobed, required 0", sb_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < N; i++) done_cnt[i] = 0;
        rst_n         = 1'b0;
        init_done     = 1'b0;
        init_t        = 1'b1;
        bus.req       = '0;
        bus.wr_en     = '0;
        bus.wr_data   = '0;
        bus_t.req     = '0;
        bus_t.wr_en   = '0;
        bus_t.wr_data = '0;
        bus_t.wr_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_port0_burst();
        test_round_robin();
        test_drop();
        test_timeout();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
